// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared widths and state/direction encodings for the block-copy engine.
//   MEM_DW/MEM_AW/MEM_LW - default data, address and length widths
//   state_t              - copy FSM states
//   dir_t                - copy direction (ascending / descending addresses)
package mem_dma_pkg;
  localparam int MEM_DW = 16;
  localparam int MEM_AW = 16;
  localparam int MEM_LW = 16;
  typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_t;
  typedef enum logic {ASC, DESC} dir_t;
endpackage

// File: rtl/mem_dma.sv
// mem_dma: memmove-style block copier driving a memory read port and write port, one word per clock.
//   clk, rst_n        - clock, asynchronous active-low reset
//   start/src/dst/len - copy request, sampled while not busy
//   busy, done        - copy in progress, one-cycle completion pulse
//   rd_addr, rd_data  - read port (data combinational from address)
//   wr_en/addr/data   - write port
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int DW = MEM_DW,
  parameter int AW = MEM_AW,
  parameter int LW = MEM_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);
  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [AW-1:0] sp_q, sp_d, dp_q, dp_d, wr_addr_q, wr_addr_d, step, last;
  logic [LW-1:0] rem_q, rem_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
  logic          accept, desc;
  always_comb begin
    accept    = start && (state_q == IDLE || state_q == DONE);
    // copying towards higher addresses must start from the top so unread source words are never clobbered
    desc      = dst > src;
    last      = AW'(len) - AW'(1);
    step      = (dir_q == DESC) ? '1 : AW'(1);
    state_d   = state_q;
    dir_d     = dir_q;
    sp_d      = sp_q;
    dp_d      = dp_q;
    rem_d     = rem_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      rem_d   = len;
      dir_d   = desc ? DESC : ASC;
      state_d = (len == '0) ? DONE : COPY;
      if (len != '0) begin
        sp_d = desc ? src + last : src;
        dp_d = desc ? dst + last : dst;
      end
    end else if (state_q == COPY) begin
      sp_d      = sp_q + step;
      dp_d      = dp_q + step;
      rem_d     = rem_q - LW'(1);
      wr_addr_d = dp_q;
      wr_data_d = rd_data;
      state_d   = (rem_q == LW'(1)) ? DRAIN : COPY;
    end else if (state_q == DRAIN) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    wr_en_d = state_q == COPY;
    busy_d  = state_d == COPY || state_d == DRAIN;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= ASC;
      sp_q      <= '0;
      dp_q      <= '0;
      rem_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      sp_q      <= sp_d;
      dp_q      <= dp_d;
      rem_q     <= rem_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_addr = sp_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: scoreboard bench for mem_dma against a memmove reference model.
module tb_mem_dma;
  typedef struct packed {logic [15:0] addr; logic [15:0] data;} wr_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        busy, done, wr_en;
  logic [15:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [15:0] mem [0:65535];
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          errors = 0, checks = 0, wr_cnt = 0;

  mem_dma dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  assign rd_data = mem[rd_addr];
  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every write the DUT presents must be the next one the model predicted
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {16'h0, wr_addr}, {16'h0, mon_e.addr});
        check("wr_data", {16'h0, wr_data}, {16'h0, mon_e.data});
      end
    end
  end

  // memmove model: the destination ends up holding the original source words; the write order
  // runs from the top when the destination lies above the source
  task automatic predict(input logic [15:0] s, input logic [15:0] d, input int n, output logic [15:0] snap[$]);
    wr_t w;
    snap = {};
    for (int i = 0; i < n; i++) snap.push_back(mem[s + 16'(i)]);
    for (int k = 0; k < n; k++) begin
      int i = (d > s) ? n - 1 - k : k;
      w.addr = d + 16'(i);
      w.data = snap[i];
      exp_q.push_back(w);
    end
  endtask

  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input int n, input bit poke);
    logic [15:0] snap[$];
    int cyc, bad;
    bit busy_seen;
    predict(s, d, n, snap);
    wr_cnt = 0;
    @(negedge clk);
    src = s; dst = d; len = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    busy_seen = busy;
    while (!done && cyc < n + 8) begin
      if (poke && cyc == 2) begin
        src = s + 16'd5; dst = d + 16'd3; len = 16'(n + 2); start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      busy_seen |= busy;
    end
    start = 1'b0;
    check("done_seen", {31'h0, done}, 32'h1);
    check("done_latency", cyc, (n == 0) ? 0 : n + 1);
    check("busy_seen", {31'h0, busy_seen}, {31'h0, n != 0});
    check("write_count", wr_cnt, n);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < n; i++) if (mem[d + 16'(i)] !== snap[i]) bad++;
    check("dest_contents_bad_words", bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pre[$];
    logic [15:0] snap[$];
    logic [15:0] s, d;
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'h0, busy}, 0);
    check("reset_done", {31'h0, done}, 0);
    check("reset_wr_en", {31'h0, wr_en}, 0);
    check("reset_rd_addr", {16'h0, rd_addr}, 0);
    check("reset_wr_addr", {16'h0, wr_addr}, 0);
    check("reset_wr_data", {16'h0, wr_data}, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 4; i++) mem[16'h10 + 16'(i)] = 16'hA1 + 16'(i);
    run_copy(16'h10, 16'h40, 4, 1'b0);
    for (int i = 0; i < 4; i++) check("asc_literal", {16'h0, mem[16'h40 + 16'(i)]}, 32'hA1 + 32'(i));

    for (int i = 0; i < 5; i++) mem[16'h20 + 16'(i)] = 16'(i + 1);
    run_copy(16'h20, 16'h22, 5, 1'b0);
    for (int i = 0; i < 5; i++) check("desc_literal", {16'h0, mem[16'h22 + 16'(i)]}, 32'(i + 1));

    for (int i = 0; i < 5; i++) mem[16'h20 + 16'(i)] = 16'(i + 1);
    run_copy(16'h22, 16'h20, 3, 1'b0);
    for (int i = 0; i < 3; i++) check("asc_overlap_literal", {16'h0, mem[16'h20 + 16'(i)]}, 32'(i + 3));

    run_copy(16'h5, 16'h9, 0, 1'b0);
    run_copy(16'h60, 16'h90, 6, 1'b1);
    run_copy(16'h90, 16'h95, 6, 1'b0);
    run_copy(16'h33, 16'h33, 4, 1'b0);

    for (int i = 0; i < 8; i++) pre.push_back(mem[16'h80 + 16'(i)]);
    predict(16'hC0, 16'h80, 8, snap);
    wr_cnt = 0;
    @(negedge clk);
    src = 16'hC0; dst = 16'h80; len = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", {31'h0, wr_en}, 0);
    check("rst_mid_busy", {31'h0, busy}, 0);
    check("rst_mid_done", {31'h0, done}, 0);
    check("rst_mid_write_count", wr_cnt, 2);
    for (int i = 0; i < 8; i++)
      check("rst_mid_mem", {16'h0, mem[16'h80 + 16'(i)]}, {16'h0, (i < 2) ? snap[i] : pre[i]});
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    run_copy(16'hC0, 16'h80, 8, 1'b0);

    for (int t = 0; t < 25; t++) begin
      s = 16'($urandom_range(16'h10, 16'h100));
      d = ($urandom_range(0, 1) == 1) ? s + 16'($urandom_range(0, 12)) - 16'd6
                                      : 16'($urandom_range(16'h10, 16'h100));
      n = int'($urandom_range(0, 12));
      run_copy(s, d, n, (n >= 2) && ($urandom_range(0, 2) == 0));
    end

    repeat (2) @(posedge clk);
    #1;
    check("idle_wr_en", {31'h0, wr_en}, 0);
    check("idle_busy", {31'h0, busy}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
